// File: rtl/wave_readout_pkg.sv
// wave_readout_pkg
//   Shared definitions for the waveform readout block: FSM state encodings,
//   default buffer-half size, RAM address width and a helper that produces
//   the last valid sample index for a given buffer size.
package wave_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  localparam int SAMPLES_DEFAULT = 256;
  localparam int ADDR_W          = 9;
  localparam int COUNT_W         = 8;
  localparam int DATA_W          = 8;

  // Index of the final sample in a buffer half; SAMPLES is at most 256 so
  // the result always fits the 8-bit sample counter.
  function automatic logic [COUNT_W-1:0] lastIndex(input int samples);
    return COUNT_W'(samples - 1);
  endfunction

endpackage

// File: rtl/wave_readout_dffare.sv
// dffare
//   Parameterised-width register with asynchronous active-low reset to zero
//   and a synchronous load enable. Every state bit of wave_readout lives in
//   one of these.
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - asynchronous reset, active low, clears q_o
//     en_i    - load enable
//     d_i     - next value
//     q_o     - registered value
module dffare #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wave_readout.sv
// wave_readout
//   Reads one completed half of a double-buffered sample RAM and presents the
//   samples one at a time to a downstream renderer with a valid/ready
//   handshake. A frame is kicked off by a start pulse while idle; the buffer
//   half is latched at that moment and held for the whole frame.
//   Ports:
//     clk               - clock, rising edge
//     reset             - asynchronous reset, active low
//     start             - frame start pulse (ignored unless idle)
//     read_index        - buffer half the capture side has completed
//     read_address      - sample RAM address {buf_sel, count}
//     read_data         - RAM data, valid one cycle after read_address
//     sample_out        - presented sample byte (offset binary, unmodified)
//     sample_x          - index of sample_out within the buffer
//     sample_valid      - sample_out/sample_x valid
//     sample_ready      - renderer accepts the presented sample
//     wave_display_idle - high while no buffer read is in progress
module wave_readout
  import wave_readout_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              read_index,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] sample_out,
  output logic [COUNT_W-1:0] sample_x,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              wave_display_idle
);

  localparam logic [COUNT_W-1:0] LAST_INDEX = lastIndex(SAMPLES);

  logic [1:0]         stateBits_q;
  state_e             state_q;
  state_e             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               bufSel_q;
  logic               bufSel_d;
  logic [DATA_W-1:0]  sampleOut_q;
  logic [COUNT_W-1:0] sampleX_q;
  logic               captureEn;

  assign state_q = state_e'(stateBits_q);

  // The RAM returns data for the address driven in ADDR during DATA, so the
  // sample and its index are captured on the edge that leaves DATA and then
  // held untouched through any PRESENT stall.
  assign captureEn = (state_q == ST_DATA);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    bufSel_d = bufSel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bufSel_d = read_index;
          count_d  = '0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (sample_ready) begin
          if (count_q == LAST_INDEX) begin
            state_d = ST_IDLE;
          end else begin
            count_d = count_q + COUNT_W'(1);
            state_d = ST_ADDR;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dffare #(.WIDTH(2)) stateReg (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (1'b1),
    .d_i   (state_d),
    .q_o   (stateBits_q)
  );

  dffare #(.WIDTH(COUNT_W)) countReg (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (1'b1),
    .d_i   (count_d),
    .q_o   (count_q)
  );

  dffare #(.WIDTH(1)) bufSelReg (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (1'b1),
    .d_i   (bufSel_d),
    .q_o   (bufSel_q)
  );

  dffare #(.WIDTH(DATA_W)) sampleOutReg (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (captureEn),
    .d_i   (read_data),
    .q_o   (sampleOut_q)
  );

  dffare #(.WIDTH(COUNT_W)) sampleXReg (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (captureEn),
    .d_i   (count_q),
    .q_o   (sampleX_q)
  );

  // The counter never passes LAST_INDEX, so the address stays inside the
  // selected buffer half in every state.
  assign read_address      = {bufSel_q, count_q};
  assign sample_out        = sampleOut_q;
  assign sample_x          = sampleX_q;
  assign sample_valid      = (state_q == ST_PRESENT);
  assign wave_display_idle = (state_q == ST_IDLE);

endmodule

// File: tb/tb_wave_readout.sv
// tb_wave_readout
//   Self-checking bench for wave_readout. A table of frame descriptions is
//   run back to back (each new start lands in the first idle cycle after the
//   previous frame); a scoreboard queue holds the samples each frame must
//   deliver. A hand-written sequence covers reset in the middle of a frame.
module tb_wave_readout;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       clkEn = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       readIndex = 1'b0;
  logic       sampleReady = 1'b1;
  logic [8:0] readAddress;
  logic [7:0] readData = 8'h00;
  logic [7:0] sampleOut;
  logic [7:0] sampleX;
  logic       sampleValid;
  logic       idle;

  logic [7:0] ram [0:511];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] data;
  } expect_t;

  expect_t sb[$];

  typedef struct {
    bit readIndex;
    int toggleAt;
    int stallAt;
    int stallLen;
    int startAt;
    bit randomReady;
    bit expBuf;
  } frame_t;

  frame_t frames[6];

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  // Synchronous RAM: data for an address appears one cycle later.
  always @(posedge clk) readData <= ram[readAddress];

  wave_readout #(.SAMPLES(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .read_index       (readIndex),
    .read_address     (readAddress),
    .read_data        (readData),
    .sample_out       (sampleOut),
    .sample_x         (sampleX),
    .sample_valid     (sampleValid),
    .sample_ready     (sampleReady),
    .wave_display_idle(idle)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time,
               actual, expected);
    end
  endtask

  // Runs one frame described by frames[idx]. Called on a falling edge with
  // the DUT idle; returns on the falling edge where idle is first seen again.
  task automatic applyStimulus(input int idx);
    frame_t  f;
    expect_t e;
    int      cycles;
    int      hs;
    int      stalls;
    int      stallLeft;
    bit      stallDone;
    bit      done;
    f         = frames[idx];
    cycles    = -1;
    hs        = 0;
    stalls    = 0;
    stallLeft = 0;
    stallDone = 0;
    done      = 0;
    checkOutput("idle_before_start", idle, 1);
    for (int i = 0; i < N; i++) begin
      e.x    = 8'(i);
      e.data = ram[(f.readIndex ? 256 : 0) + i];
      sb.push_back(e);
    end
    start       = 1'b1;
    readIndex   = f.readIndex;
    sampleReady = 1'b1;
    while (!done) begin
      @(negedge clk);
      start = 1'b0;
      // cycles counts edges since the edge that accepted start
      cycles++;
      if (hs == N) begin
        checkOutput("idle_after_frame", idle, 1);
        checkOutput("frame_cycles", cycles, 3 * N + stalls);
        checkOutput("scoreboard_empty", sb.size(), 0);
        done = 1;
      end else if (cycles > 3 * N + stalls + 20) begin
        checkOutput("frame_timeout", cycles, 3 * N + stalls);
        sb.delete();
        done = 1;
      end else begin
        checkOutput("busy_during_frame", idle, 0);
        checkOutput("read_address", readAddress, {f.expBuf, 8'(hs)});
        if (f.toggleAt >= 0 && hs >= f.toggleAt) readIndex = ~f.readIndex;
        if (f.startAt >= 0 && sampleValid && hs == f.startAt) start = 1'b1;
        if (sampleValid) begin
          if (!f.randomReady && !stallDone && f.stallAt >= 0 && hs == f.stallAt) begin
            stallLeft = f.stallLen;
            stallDone = 1;
          end
          if (f.randomReady) begin
            sampleReady = 1'($urandom_range(0, 1));
          end else if (stallLeft > 0) begin
            sampleReady = 1'b0;
            stallLeft--;
          end else begin
            sampleReady = 1'b1;
          end
          if (sampleReady) begin
            e = sb.pop_front();
            checkOutput("sample_x", sampleX, e.x);
            checkOutput("sample_out", sampleOut, e.data);
            hs++;
          end else begin
            stalls++;
            checkOutput("hold_sample_x", sampleX, sb[0].x);
            checkOutput("hold_sample_out", sampleOut, sb[0].data);
          end
        end
      end
    end
    sampleReady = 1'b1;
  endtask

  initial begin
    bit hit;
    for (int n = 0; n < 512; n++) ram[n] = 8'(n ^ 'h5A);

    frames[0] = '{readIndex:1'b1, toggleAt:-1, stallAt:-1, stallLen:0, startAt:-1, randomReady:1'b0, expBuf:1'b1};
    frames[1] = '{readIndex:1'b0, toggleAt:10, stallAt:-1, stallLen:0, startAt:-1, randomReady:1'b0, expBuf:1'b0};
    frames[2] = '{readIndex:1'b0, toggleAt:-1, stallAt:7,  stallLen:5, startAt:-1, randomReady:1'b0, expBuf:1'b0};
    frames[3] = '{readIndex:1'b1, toggleAt:50, stallAt:-1, stallLen:0, startAt:50, randomReady:1'b0, expBuf:1'b1};
    frames[4] = '{readIndex:1'b0, toggleAt:-1, stallAt:-1, stallLen:0, startAt:-1, randomReady:1'b1, expBuf:1'b0};
    frames[5] = '{readIndex:1'b1, toggleAt:-1, stallAt:-1, stallLen:0, startAt:-1, randomReady:1'b0, expBuf:1'b1};

    // Reset with the clock stopped
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("reset_read_address", readAddress, 0);
    checkOutput("reset_sample_out", sampleOut, 0);
    checkOutput("reset_sample_x", sampleX, 0);
    checkOutput("reset_sample_valid", sampleValid, 0);
    checkOutput("reset_idle", idle, 1);

    clkEn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) applyStimulus(i);

    // Reset in the middle of a frame reading buffer half 0
    start       = 1'b1;
    readIndex   = 1'b0;
    sampleReady = 1'b1;
    hit         = 0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sampleValid && sampleX == 8'd100) hit = 1;
    end
    checkOutput("reached_sample_100", hit, 1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_sample_valid", sampleValid, 0);
    checkOutput("midreset_idle", idle, 1);
    checkOutput("midreset_read_address", readAddress, 0);
    checkOutput("midreset_sample_x", sampleX, 0);
    checkOutput("midreset_sample_out", sampleOut, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_readout.md
WAVE_READOUT -- requirements
Module: wave_readout

Interface
REQ-001 Parameter SAMPLES, default 256: samples per buffer half; legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  frame-start pulse, one cycle wide, e.g. vsync edge.
REQ-005 read_index  input  1  selects the buffer half the capture side has completed.
REQ-006 read_address  output  9  sample RAM read address.
REQ-007 read_data  input  8  RAM read data, valid exactly 1 cycle after read_address.
REQ-008 sample_out  output  8  sample byte, offset-binary (0x80 = zero), passed through unmodified.
REQ-009 sample_x  output  8  index of sample_out within the buffer, 0..SAMPLES-1.
REQ-010 sample_valid  output  1  sample_out and sample_x are valid.
REQ-011 sample_ready  input  1  downstream renderer accepts the sample.
REQ-012 wave_display_idle  output  1  high when no buffer read is in progress.

Function
REQ-013 Four-state FSM: IDLE, ADDR, DATA, PRESENT.
REQ-014 IDLE: on start=1, latch read_index into buf_sel, clear count to 0, go to ADDR; otherwise stay in IDLE.
REQ-015 ADDR: drive read_address = {buf_sel, count}, go to DATA next cycle.
REQ-016 DATA: capture read_data into the output register, set sample_x = count, go to PRESENT.
REQ-017 PRESENT: sample_valid=1; on sample_ready=1, handshake completes; if count == SAMPLES-1 go to IDLE, else count+1 and go to ADDR.
REQ-018 PRESENT with sample_ready=0: hold sample_out, sample_x and sample_valid stable.
REQ-019 Minimum throughput: one sample per 3 cycles with sample_ready tied high.
REQ-020 read_address = {buf_sel, count[7:0]} in every state; the 9-bit address never exceeds {buf_sel, SAMPLES-1}.
REQ-021 buf_sel is frozen for the whole frame; toggling read_index mid-frame has no effect until the next accepted start.
REQ-022 start while not in IDLE is ignored; no queuing.
REQ-023 wave_display_idle = 1 exactly when the state is IDLE, combinationally from state.
REQ-024 Same cycle as the final handshake: wave_display_idle rises on the next edge; a start in that first IDLE cycle is accepted.
REQ-025 sample_valid = 1 only in PRESENT.

Reset
REQ-026 Asserting reset forces IDLE immediately, independent of clk.
REQ-027 Reset values: count=0, buf_sel=0, read_address=0, sample_out=0, sample_x=0, sample_valid=0, wave_display_idle=1.
REQ-028 Reset mid-frame abandons the frame; the first start after deassertion begins at sample_x=0.

Structure
REQ-029 A shared package holds the FSM state encodings (2-bit) and the SAMPLES default and address width (9).
REQ-030 All registers are built from one sub-module, dffare: a parameterised-width register with async active-low reset and enable.
REQ-031 The next-state and next-count logic is one combinational block with a default arm returning to IDLE.

Verification
REQ-032 Check: reset low, then high, clk idle -> all outputs at reset values, wave_display_idle=1.
REQ-033 Check: RAM preloaded addr n=n^0x5A, read_index=1, start, sample_ready=1 -> 256 handshakes.
- Each handshake has sample_x=0..255, sample_out=RAM[256+x], and read_address in 256..511.
- Frame lasts 768 cycles; wave_display_idle returns to 1.
REQ-034 Check: read_index=0, start, then read_index toggles at sample 10 -> all addresses stay 0..255, sample_out=RAM[x].
REQ-035 Check: sample_ready low for 5 cycles at sample_x=7 -> sample_out and sample_x held stable, no skipped or duplicated sample_x.
REQ-036 Check: start pulses at sample_x=50 -> ignored, frame still ends at sample_x=255.
- A start in the first IDLE cycle after the frame begins a new frame at sample_x=0.
REQ-037 Check: reset asserted at sample_x=100 -> immediate IDLE and sample_valid=0; the next start restarts at sample_x=0 with buf_sel from the new start.
